// File: rtl/icache_axi_rd_bridge.sv
// Icache read-port to AXI4 read-channel bridge: one outstanding request,
// AR burst issue, and a registered return of each R beat to the cache.
module icache_axi_rd_bridge #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [2:0]  rd_type,
  input  logic [31:0] rd_addr,
  output logic        rd_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        resp_err
);
  localparam int          OFF       = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_req_t;

  logic [1:0] state;
  ar_req_t    dec, ar_q;
  logic [7:0] cnt;
  logic       beat, final_beat;

  // Burst end comes from our own beat count; the slave's rlast is not trusted.
  logic unused_rsp;
  assign unused_rsp = ^{rlast, rresp[0]};

  always_comb begin
    dec = '{addr: rd_addr, len: 8'd0, size: 3'd2};
    case (rd_type)
      3'b100: dec = '{addr: rd_addr & LINE_MASK, len: LINE_LEN, size: 3'd2};
      3'b001: dec.size = 3'd1;
      3'b000: dec.size = 3'd0;
      default: ;
    endcase
  end

  assign rd_rdy     = (state == S_IDLE);
  assign arvalid    = (state == S_AR);
  assign rready     = (state == S_R);
  assign beat       = rready && rvalid;
  assign final_beat = beat && (cnt == ar_q.len);

  assign arid    = AXI_ID;
  assign arburst = 2'b01;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ar_q  <= '0;
      cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (rd_req) begin
          ar_q  <= dec;
          cnt   <= 8'd0;
          state <= S_AR;
        end
        S_AR: if (arready) state <= S_R;
        S_R: if (beat) begin
          cnt <= cnt + 8'd1;
          if (final_beat) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return path is one register stage behind the R handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      ret_valid <= beat;
      ret_last  <= final_beat;
      resp_err  <= beat && rresp[1];
      if (beat) ret_data <= rdata;
    end
  end
endmodule

// File: doc/icache_axi_rd_bridge.md
# icache_axi_rd_bridge

Read-only bridge between the instruction cache's bus-side read port and an AXI4 read channel. It accepts one cache read request at a time (single word or full cache line), issues the matching AXI AR burst and returns the R beats to the cache as registered `ret_valid`/`ret_last`/`ret_data`. It sits between the icache and the AXI interconnect/arbiter, and is the responder end of the cache's `rd_req`/`rd_rdy`/`ret_*` protocol.

## Interface
Parameters:
- `LINE_WORDS`, 4, words per cache line; power of two, 2..16.
- `AXI_ID`, 4'd0, constant value driven on `arid`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_req`  in  1  cache read request valid.
- `rd_type`  in  3  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line.
- `rd_addr`  in  32  request start address.
- `rd_rdy`  out  1  request can be accepted this cycle.
- `ret_valid`  out  1  `ret_data` valid this cycle.
- `ret_last`  out  1  final beat of the current request.
- `ret_data`  out  32  returned data.
- `arid`  out  4  equals `AXI_ID`.
- `araddr`  out  32  AXI read address.
- `arlen`  out  8  beats minus 1.
- `arsize`  out  3  bytes per beat, log2.
- `arburst`  out  2  fixed 2'b01 (INCR).
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rdata`  in  32  R data.
- `rresp`  in  2  R response.
- `rlast`  in  1  R last; ignored, see Operation.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.
- `resp_err`  out  1  pulses with `ret_valid` when that beat had `rresp[1]`=1.

## Operation
- FSM states: IDLE, AR, R.
- IDLE:
  - `rd_rdy`=1.
  - `rd_req`&&`rd_rdy` latches `rd_type` and `rd_addr`, clears the beat counter, goes to AR.
- AR:
  - `arvalid`=1; address and control held stable until `arready`.
  - `arvalid`&&`arready` goes to R.
- R:
  - `rready`=1.
  - Each `rvalid`&&`rready` beat increments the counter.
  - The final beat goes to IDLE.
- Request decode, fixed at acceptance:
  - line (3'b100): `araddr`={`rd_addr`[31:OFF], OFF zeros} with OFF=log2(`LINE_WORDS`)+2; `arsize`=3'd2; `arlen`=`LINE_WORDS`-1.
  - word (3'b010): `araddr`=`rd_addr`; `arsize`=3'd2; `arlen`=0.
  - half (3'b001): `arsize`=3'd1; `arlen`=0.
  - byte (3'b000): `arsize`=3'd0; `arlen`=0.
  - Encodings 3'b011, 3'b101–3'b111 are treated as word.
- Final beat is the counter reaching `arlen`; `rlast` is not used. `rdata` passes through unmodified, with no byte lane shifting.
- `rid` is not checked. `rresp` only drives `resp_err`; the beat is still returned.
- Only one outstanding request. `rd_rdy`=0 in AR and R.

## Timing
- Reset values: FSM=IDLE, `rd_rdy`=1, `arvalid`=0, `rready`=0, `ret_valid`=0, `ret_last`=0, `ret_data`=0, `resp_err`=0, `araddr`=0, `arlen`=0, `arsize`=0. `arburst`=2'b01 and `arid`=`AXI_ID` are constant.
- `arvalid` rises the cycle after request acceptance, so request-to-AR latency is 1 cycle.
- `ret_valid`/`ret_data`/`ret_last`/`resp_err` are registered: asserted exactly one cycle after the accepting R beat, for one cycle each. There is no cache-side backpressure.
- `rd_rdy` returns to 1 in the same cycle `ret_last` is high. A new request may be accepted in that cycle.
- `arready` already high when `arvalid` first rises: handshake completes in that cycle.
- `rvalid` gaps: the counter holds and `ret_valid` is 0 the following cycle.
- Reset asserted mid-operation: immediate return to IDLE with reset values, and in-flight beats are discarded. The AXI slave shares `reset`.

## Test plan
- Line read, `LINE_WORDS`=4, `rd_addr`=32'h1C00_0014:
  - AR: `araddr`=32'h1C00_0010, `arlen`=3, `arsize`=2, `arburst`=1.
  - Beats 11,22,33,44 back-to-back → `ret_data` 11,22,33,44 on 4 consecutive cycles, each one cycle after its beat; `ret_last` only with 44.
- Word read at 32'h8000_0004 with `arready` delayed 3 cycles:
  - `arvalid` and `araddr` held stable 4 cycles; `arlen`=0.
  - One `ret_valid` with `ret_last`=1.
- Line read, `rvalid` pattern 1,0,0,1,1,0,1:
  - 4 `ret_valid` pulses mirroring the beats, delayed one cycle.
  - `rlast` forced 0 throughout → `ret_last` still on beat 4.
- Back-to-back: `rd_req` held high → second request accepted in the `ret_last` cycle; next `arvalid` rises one cycle later.
- Beat 2 of a line with `rresp`=2'b10 → `resp_err`=1 only with that beat's `ret_valid`; all 4 beats still returned.
- `reset` pulsed during R after beat 1 → all outputs at reset values and `rd_rdy`=1 immediately; a fresh word request then completes normally.
